muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the operand and result width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port Start, input, 1 bit: decode asserts it for an M-extension op (Mul=1).
REQ-005 The block SHALL have port Funct3, input, 3 bits: M-op select (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-006 The block SHALL have ports SrcA and SrcB, input, DATA_WIDTH bits each: rs1 and rs2 operands.
REQ-007 The block SHALL have port Flush, input, 1 bit: pipeline flush that aborts any op in progress.
REQ-008 The block SHALL have port Stall, output, 1 bit: freezes PC and the decode/execute registers.
REQ-009 The block SHALL have port Done, output, 1 bit: one-cycle pulse marking Result valid.
REQ-010 The block SHALL have port Result, output, DATA_WIDTH bits: the rd writeback value.
REQ-011 The block SHALL have port Busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 The block SHALL have port Illegal, output, 1 bit: one-cycle pulse marking a rejected op.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-014 Start SHALL be accepted only in IDLE or DONE. At that edge the block SHALL latch Funct3, the operand magnitudes and the sign flags, load the step counter with DATA_WIDTH-1, and enter CALC.
REQ-015 Start SHALL be ignored while in CALC.
REQ-016 Each CALC cycle SHALL perform one radix-2 step: shift-add for multiply, restoring subtract-shift for divide. The counter SHALL decrement each step.
REQ-017 The block SHALL leave CALC for DONE after the step with counter==0, i.e. after exactly DATA_WIDTH CALC cycles.
REQ-018 If Start is accepted at edge k, Done SHALL be high during cycle k+DATA_WIDTH+1, i.e. cycle k+33 at the default width.
REQ-019 MUL SHALL return the low DATA_WIDTH bits of the product.
REQ-020 MULH, MULHSU and MULHU SHALL return the high DATA_WIDTH bits of the 2*DATA_WIDTH product, with signed x signed, signed x unsigned and unsigned x unsigned operands respectively.
REQ-021 Signed ops SHALL use a magnitude iteration with the sign fixed up in DONE. The remainder SHALL take the sign of the dividend.
REQ-022 Division by zero SHALL skip CALC, enter DONE at the next edge, and return quotient all-ones and remainder = SrcA.
REQ-023 Signed overflow (SrcA=most-negative, SrcB=-1) SHALL skip CALC and return quotient = SrcA and remainder 0.
REQ-024 Stall SHALL be combinational and equal (Start & state==IDLE) | (state==CALC) | (Start & state==DONE & the new op is not a 1-cycle special case).
REQ-025 Stall SHALL be low during the DONE cycle that completes a op with no new Start, so the pipeline captures Result.
REQ-026 In DONE without Start, the FSM SHALL return to IDLE at the next edge.
REQ-027 In DONE with Start (back-to-back), the Result and Done of the completing op SHALL be presented and the new op accepted in the same cycle.
REQ-028 Result SHALL hold its last value outside DONE.
REQ-029 Flush SHALL have priority over Start: from any state the FSM SHALL go to IDLE at the next edge, no Done for the aborted op, and Start in that same cycle ignored.

Reset
REQ-030 rst high SHALL asynchronously force state=IDLE, counter=0, Result=0, Stall=0, Done=0, Busy=0, Illegal=0 and clear all latched operands and flags.
REQ-031 An op in progress when rst asserts SHALL be discarded, and no Done SHALL follow deassertion.

Configuration
REQ-032 With MULDIV_DIV_EN defined, all eight Funct3 codes SHALL execute as specified above.
REQ-033 Without MULDIV_DIV_EN, a Start with Funct3[2]=1 SHALL be rejected: state stays or goes to IDLE, Illegal pulses in the next cycle, Stall and Done stay low, and no divider logic is synthesized.

Structure
REQ-034 Package muldiv_pkg SHALL hold the state enum typedef, the eight Funct3 localparams and the step-count width constant.
REQ-035 Sub-module muldiv_iter_core SHALL hold the accumulator/remainder and shift registers plus the adder/subtractor. The FSM, special-case detection and sign fix-up SHALL stay in muldiv_sequencer.

Verification
REQ-036 MUL with SrcA=7, SrcB=-3: Stall high for 33 cycles, Done at k+33, Result=32'hFFFFFFEB.
REQ-037 MULHU with SrcA=SrcB=32'hFFFFFFFF: Result=32'hFFFFFFFE. MULH with -1 x -1: Result=0.
REQ-038 DIV with -7 / 2: quotient 32'hFFFFFFFD. REM with -7 / 2: 32'hFFFFFFFF. DIVU with 100 / 0: 32'hFFFFFFFF at k+1. DIV with 32'h80000000 / -1: 32'h80000000 at k+1.
REQ-039 Flush asserted in CALC cycle 10: Busy low next cycle, no Done. A new Start two cycles later completes normally.
REQ-040 Back-to-back: second Start in the DONE cycle. Both Done pulses occur 33 cycles apart and both Results are correct.
REQ-041 rst asserted mid-CALC: outputs zero immediately, with no clock edge needed. Without MULDIV_DIV_EN, REMU gives Illegal=1 for one cycle and Stall=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the iterative multiply/divide sequencer
package muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Step counter width; covers operand widths up to 64 bits.
    localparam int CNT_W = 6;

endpackage

// File: rtl/muldiv_iter_core.sv
// rtl/muldiv_iter_core.sv - radix-2 shift-add multiply / restoring divide datapath
// Divide path present only when MULDIV_DIV_EN is defined.
module muldiv_iter_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
`ifdef MULDIV_DIV_EN
    input  logic                  is_div,
`endif
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    logic [DATA_WIDTH-1:0] hi_q, lo_q, opnd_q;
    logic [DATA_WIDTH-1:0] hi_n, lo_n;
    logic [DATA_WIDTH:0]   mul_sum;

    // hi:lo is the running product (multiplier shifts out of lo) or remainder:dividend.
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);

`ifdef MULDIV_DIV_EN
    logic [DATA_WIDTH:0] div_shift;
    assign div_shift = {hi_q, lo_q[DATA_WIDTH-1]};
`endif

    always_comb begin
        hi_n = mul_sum[DATA_WIDTH:1];
        lo_n = {mul_sum[0], lo_q[DATA_WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        if (is_div) begin
            if (div_shift >= {1'b0, opnd_q}) begin
                hi_n = DATA_WIDTH'(div_shift - {1'b0, opnd_q});
                lo_n = {lo_q[DATA_WIDTH-2:0], 1'b1};
            end else begin
                hi_n = div_shift[DATA_WIDTH-1:0];
                lo_n = {lo_q[DATA_WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
        end else if (load) begin
            hi_q   <= '0;
            lo_q   <= op_a;
            opnd_q <= op_b;
        end else if (step) begin
            hi_q <= hi_n;
            lo_q <= lo_n;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - M-extension sequencer: FSM, special cases, sign fix-up
// Define MULDIV_DIV_EN to enable DIV/DIVU/REM/REMU; otherwise they raise Illegal.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic                  Flush,
    output logic                  Stall,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Busy,
    output logic                  Illegal
);

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt_q;
    logic [2:0]            funct3_q;
    logic                  neg_q, special_q, illegal_q;
    logic [DATA_WIDTH-1:0] spec_val_q, result_q;

    logic                  a_signed, b_signed, a_neg, b_neg, neg_n;
    logic                  special_n, reject, can_accept, accept, reject_hit;
    logic [DATA_WIDTH-1:0] mag_a, mag_b, spec_val_n, done_val, hi_fix;
    logic [DATA_WIDTH-1:0] core_hi, core_lo;

    // Operand decode: magnitudes, sign flags and one-cycle special cases.
    always_comb begin
        a_signed   = 1'b0;
        b_signed   = 1'b0;
        special_n  = 1'b0;
        spec_val_n = '0;
        reject     = 1'b0;
        case (Funct3)
            F3_MULH:        begin a_signed = 1'b1; b_signed = 1'b1; end
            F3_MULHSU:      a_signed = 1'b1;
            F3_DIV, F3_REM: begin a_signed = 1'b1; b_signed = 1'b1; end
            default:        ;
        endcase
        a_neg = a_signed & SrcA[DATA_WIDTH-1];
        b_neg = b_signed & SrcB[DATA_WIDTH-1];
        mag_a = a_neg ? -SrcA : SrcA;
        mag_b = b_neg ? -SrcB : SrcB;
        // Remainder follows the dividend; everything else follows the operand sign product.
        neg_n = (Funct3 == F3_REM) ? a_neg : (a_neg ^ b_neg);
`ifdef MULDIV_DIV_EN
        if (Funct3[2] && SrcB == '0) begin
            special_n  = 1'b1;
            spec_val_n = Funct3[1] ? SrcA : '1;
        end else if (a_signed && Funct3[2] && SrcB == '1 &&
                     SrcA == {1'b1, {(DATA_WIDTH-1){1'b0}}}) begin
            special_n  = 1'b1;
            spec_val_n = Funct3[1] ? '0 : SrcA;
        end
`else
        reject = Funct3[2];
`endif
    end

    assign can_accept = (state == ST_IDLE || state == ST_DONE) && !Flush;
    assign accept     = Start && can_accept && !reject;
    assign reject_hit = Start && can_accept && reject;

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE, ST_DONE: state_n = accept ? (special_n ? ST_DONE : ST_CALC) : ST_IDLE;
            ST_CALC: begin
                if (Flush)
                    state_n = ST_IDLE;
                else if (cnt_q == '0)
                    state_n = ST_DONE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    muldiv_iter_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .step   (state == ST_CALC),
`ifdef MULDIV_DIV_EN
        .is_div (funct3_q[2]),
`endif
        .op_a   (mag_a),
        .op_b   (mag_b),
        .hi     (core_hi),
        .lo     (core_lo)
    );

    // High half of the two's-complement negated product: ~hi plus the carry out of ~lo+1.
    assign hi_fix = neg_q ? (~core_hi + {{(DATA_WIDTH-1){1'b0}}, (core_lo == '0)}) : core_hi;

    always_comb begin
        done_val = core_lo;
        case (funct3_q)
            F3_MUL:                       done_val = core_lo;
            F3_MULH, F3_MULHSU, F3_MULHU: done_val = hi_fix;
`ifdef MULDIV_DIV_EN
            F3_DIV, F3_DIVU:              done_val = neg_q ? -core_lo : core_lo;
            F3_REM, F3_REMU:              done_val = neg_q ? -core_hi : core_hi;
`endif
            default:                      done_val = core_lo;
        endcase
        if (special_q)
            done_val = spec_val_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt_q      <= '0;
            funct3_q   <= '0;
            neg_q      <= 1'b0;
            special_q  <= 1'b0;
            spec_val_q <= '0;
            result_q   <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state     <= state_n;
            illegal_q <= reject_hit;
            if (state == ST_DONE)
                result_q <= done_val;
            if (accept) begin
                funct3_q   <= Funct3;
                neg_q      <= neg_n;
                special_q  <= special_n;
                spec_val_q <= spec_val_n;
                cnt_q      <= CNT_W'(DATA_WIDTH - 1);
            end else if (state == ST_CALC && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign Stall   = !rst && ((Start && !reject && state == ST_IDLE) ||
                              (state == ST_CALC) ||
                              (Start && !reject && !special_n && state == ST_DONE));
    assign Done    = (state == ST_DONE);
    assign Busy    = (state != ST_IDLE);
    assign Result  = (state == ST_DONE) ? done_val : result_q;
    assign Illegal = illegal_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst, Start, Flush;
    logic [2:0]  Funct3;
    logic [31:0] SrcA, SrcB, Result;
    logic        Stall, Done, Busy, Illegal;

    int n_cmp = 0;
    int n_bad = 0;
    int lat, stl, dcnt;

    always #5 clk = ~clk;

    muldiv_sequencer #(.DATA_WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .Start   (Start),
        .Funct3  (Funct3),
        .SrcA    (SrcA),
        .SrcB    (SrcB),
        .Flush   (Flush),
        .Stall   (Stall),
        .Done    (Done),
        .Result  (Result),
        .Busy    (Busy),
        .Illegal (Illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Start  = 1'b1;
        Funct3 = f3;
        SrcA   = a;
        SrcB   = b;
        #1;
    endtask

    // l: cycles from the Start cycle to the Done cycle; s: Stall-high cycles incl. the Start cycle.
    task automatic wait_done(output int l, output int s);
        l = 0;
        s = 1;
        do begin
            @(negedge clk);
            Start = 1'b0;
            #1;
            l++;
            if (Stall && !Done) s++;
        end while (!Done && l < 100);
    endtask

    initial begin
        rst = 1'b1; Start = 1'b0; Flush = 1'b0; Funct3 = 3'b000; SrcA = '0; SrcB = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy",    Busy,    0);
        chk("rst_done",    Done,    0);
        chk("rst_stall",   Stall,   0);
        chk("rst_result",  Result,  0);
        chk("rst_illegal", Illegal, 0);
        rst = 1'b0;

        // MUL 7 x -3
        start_op(3'b000, 32'd7, 32'hFFFFFFFD);
        chk("mul_stall_start", Stall, 1);
        wait_done(lat, stl);
        chk("mul_latency", lat, 33);
        chk("mul_stall_cycles", stl, 33);
        chk("mul_done", Done, 1);
        chk("mul_stall_done", Stall, 0);
        chk("mul_result", Result, 32'hFFFFFFEB);
        @(negedge clk); #1;
        chk("mul_done_drop", Done, 0);
        chk("mul_idle", Busy, 0);
        chk("mul_result_hold", Result, 32'hFFFFFFEB);

        start_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(lat, stl);
        chk("mulhu_latency", lat, 33);
        chk("mulhu_result", Result, 32'hFFFFFFFE);

        start_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(lat, stl);
        chk("mulh_result", Result, 32'h00000000);

        // -1 (signed) x 2 (unsigned) = -2, high word all ones
        start_op(3'b010, 32'hFFFFFFFF, 32'd2);
        wait_done(lat, stl);
        chk("mulhsu_result", Result, 32'hFFFFFFFF);

`ifdef MULDIV_DIV_EN
        start_op(3'b100, 32'hFFFFFFF9, 32'd2);
        wait_done(lat, stl);
        chk("div_latency", lat, 33);
        chk("div_result", Result, 32'hFFFFFFFD);

        start_op(3'b110, 32'hFFFFFFF9, 32'd2);
        wait_done(lat, stl);
        chk("rem_result", Result, 32'hFFFFFFFF);

        start_op(3'b111, 32'd100, 32'd7);
        wait_done(lat, stl);
        chk("remu_result", Result, 32'd2);
        chk("remu_illegal", Illegal, 0);

        start_op(3'b101, 32'd100, 32'd0);
        chk("divu0_stall_start", Stall, 1);
        wait_done(lat, stl);
        chk("divu0_latency", lat, 1);
        chk("divu0_stall_cycles", stl, 1);
        chk("divu0_result", Result, 32'hFFFFFFFF);

        start_op(3'b110, 32'd100, 32'd0);
        wait_done(lat, stl);
        chk("rem0_result", Result, 32'd100);

        start_op(3'b100, 32'h80000000, 32'hFFFFFFFF);
        wait_done(lat, stl);
        chk("divovf_latency", lat, 1);
        chk("divovf_result", Result, 32'h80000000);
`endif

        // Back-to-back: second Start during the first op's DONE cycle
        start_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(lat, stl);
        chk("b2b_first_latency", lat, 33);
        Start = 1'b1; Funct3 = 3'b000; SrcA = 32'd7; SrcB = 32'hFFFFFFFD;
        #1;
        chk("b2b_first_done", Done, 1);
        chk("b2b_first_result", Result, 32'h00000000);
        chk("b2b_stall", Stall, 1);
        wait_done(lat, stl);
        chk("b2b_gap", lat, 33);
        chk("b2b_second_result", Result, 32'hFFFFFFEB);

        // Flush in CALC cycle 10
        start_op(3'b000, 32'd7, 32'hFFFFFFFD);
        repeat (10) begin
            @(negedge clk);
            Start = 1'b0;
        end
        Flush = 1'b1;
        @(negedge clk);
        Flush = 1'b0;
        #1;
        chk("flush_busy", Busy, 0);
        chk("flush_done", Done, 0);
        start_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(lat, stl);
        chk("post_flush_latency", lat, 33);
        chk("post_flush_result", Result, 32'hFFFFFFFE);

        // Asynchronous reset mid-CALC
        start_op(3'b000, 32'd7, 32'hFFFFFFFD);
        repeat (5) begin
            @(negedge clk);
            Start = 1'b0;
        end
        #1;
        chk("pre_rst_hold", Result, 32'hFFFFFFFE);
        rst = 1'b1;
        #1;
        chk("arst_busy",   Busy,   0);
        chk("arst_stall",  Stall,  0);
        chk("arst_done",   Done,   0);
        chk("arst_result", Result, 0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        repeat (40) begin
            @(negedge clk); #1;
            if (Done) dcnt++;
        end
        chk("arst_no_done", dcnt, 0);
        chk("arst_idle", Busy, 0);

`ifndef MULDIV_DIV_EN
        start_op(3'b111, 32'd100, 32'd7);
        chk("illegal_stall_start", Stall, 0);
        @(negedge clk);
        Start = 1'b0;
        #1;
        chk("illegal_pulse", Illegal, 1);
        chk("illegal_stall", Stall, 0);
        chk("illegal_busy", Busy, 0);
        chk("illegal_done", Done, 0);
        @(negedge clk); #1;
        chk("illegal_drop", Illegal, 0);
        chk("illegal_done2", Done, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
